// File: rtl/yellow_blob_tracker.sv
// ============================================================================
//  Module   : yellow_blob_tracker
//  Purpose  : Per-frame yellow pixel count and bounding box from a mask stream,
//             reported on a valid/ready handshake. YELLOW_CENTROID_EN adds a
//             serial-divider centroid (res_cx/res_cy).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module yellow_blob_tracker #(
    parameter int H_MAX   = 640,
    parameter int V_MAX   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int CNT_W   = 19,
    parameter int MIN_PIX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mask_valid,
    input  logic             mask_bit,
    input  logic             mask_sof,
    input  logic             mask_eol,
    input  logic             mask_eof,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [CNT_W-1:0] res_count,
    output logic [X_W-1:0]   res_xmin,
    output logic [X_W-1:0]   res_xmax,
    output logic [Y_W-1:0]   res_ymin,
    output logic [Y_W-1:0]   res_ymax,
`ifdef YELLOW_CENTROID_EN
    output logic [X_W-1:0]   res_cx,
    output logic [Y_W-1:0]   res_cy,
`endif
    output logic             frame_drop
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
`ifdef YELLOW_CENTROID_EN
    localparam logic [1:0] S_DIV    = 2'd2;
`endif
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [X_W-1:0]   c_X_LAST  = X_W'(H_MAX - 1);
    localparam logic [Y_W-1:0]   c_Y_LAST  = Y_W'(V_MAX - 1);
    localparam logic [CNT_W-1:0] c_MIN_PIX = CNT_W'(MIN_PIX);

    logic [1:0]       r_state;
    logic [1:0]       w_state_n;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [CNT_W-1:0] r_count;
    logic [X_W-1:0]   r_xmin, r_xmax;
    logic [Y_W-1:0]   r_ymin, r_ymax;

    logic             r_res_found;
    logic [CNT_W-1:0] r_res_count;
    logic [X_W-1:0]   r_res_xmin, r_res_xmax;
    logic [Y_W-1:0]   r_res_ymin, r_res_ymax;

    logic             w_take, w_eof_take, w_busy;
    logic [X_W-1:0]   w_cur_x, w_nxt_x;
    logic [Y_W-1:0]   w_cur_y, w_nxt_y;
    logic [CNT_W-1:0] w_base_cnt, w_count_n;
    logic             w_first, w_add;
    logic [X_W-1:0]   w_xmin_n, w_xmax_n;
    logic [Y_W-1:0]   w_ymin_n, w_ymax_n;
    logic             w_found_n;

    // A sof pixel is always (0,0) with an empty accumulator, even mid-frame.
    always_comb begin
        w_take     = mask_valid && ((r_state == S_ACCUM) || ((r_state == S_IDLE) && mask_sof));
        w_eof_take = w_take && mask_eof;
        w_cur_x    = mask_sof ? '0 : r_x;
        w_cur_y    = mask_sof ? '0 : r_y;
        w_nxt_x    = mask_eol ? '0 : ((w_cur_x == c_X_LAST) ? c_X_LAST : w_cur_x + 1'b1);
        w_nxt_y    = !mask_eol ? w_cur_y : ((w_cur_y == c_Y_LAST) ? c_Y_LAST : w_cur_y + 1'b1);
        w_base_cnt = mask_sof ? '0 : r_count;
        w_first    = (w_base_cnt == '0);
        w_add      = mask_bit && !(&w_base_cnt);
        w_count_n  = w_add ? w_base_cnt + 1'b1 : w_base_cnt;
        w_xmin_n   = r_xmin;
        w_xmax_n   = r_xmax;
        w_ymin_n   = r_ymin;
        w_ymax_n   = r_ymax;
        if (mask_bit) begin
            if (w_first || (w_cur_x < r_xmin)) w_xmin_n = w_cur_x;
            if (w_first || (w_cur_x > r_xmax)) w_xmax_n = w_cur_x;
            if (w_first || (w_cur_y < r_ymin)) w_ymin_n = w_cur_y;
            if (w_first || (w_cur_y > r_ymax)) w_ymax_n = w_cur_y;
        end
        w_found_n  = (w_count_n >= c_MIN_PIX);
    end

`ifdef YELLOW_CENTROID_EN
    localparam int c_QW = (X_W > Y_W) ? X_W : Y_W;
    localparam int c_SW = $clog2(X_W + Y_W + 1);
    localparam logic [c_SW-1:0] c_STEP_X_END = c_SW'(X_W - 1);
    localparam logic [c_SW-1:0] c_STEP_END   = c_SW'(X_W + Y_W - 1);

    logic [X_W+CNT_W-1:0] r_sum_x, w_sum_x_n;
    logic [Y_W+CNT_W-1:0] r_sum_y, w_sum_y_n;
    logic [CNT_W-1:0]     r_div_rem, w_div_rem_n;
    logic [c_QW-1:0]      r_div_lo, r_div_q, w_div_q_n;
    logic [c_SW-1:0]      r_div_step;
    logic [CNT_W:0]       w_div_t;
    logic                 w_div_ge;
    logic [X_W-1:0]       r_res_cx;
    logic [Y_W-1:0]       r_res_cy;

    // Restoring step: the remainder starts as the high part of the sum, which is
    // already below the count because the average coordinate fits X_W/Y_W bits.
    always_comb begin
        w_sum_x_n   = (mask_sof ? '0 : r_sum_x) + (w_add ? (X_W+CNT_W)'(w_cur_x) : '0);
        w_sum_y_n   = (mask_sof ? '0 : r_sum_y) + (w_add ? (Y_W+CNT_W)'(w_cur_y) : '0);
        w_div_t     = {r_div_rem, r_div_lo[c_QW-1]};
        w_div_ge    = (w_div_t >= {1'b0, r_count});
        w_div_rem_n = w_div_ge ? CNT_W'(w_div_t - {1'b0, r_count}) : w_div_t[CNT_W-1:0];
        w_div_q_n   = {r_div_q[c_QW-2:0], w_div_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_x    <= '0;
            r_sum_y    <= '0;
            r_div_rem  <= '0;
            r_div_lo   <= '0;
            r_div_q    <= '0;
            r_div_step <= '0;
            r_res_cx   <= '0;
            r_res_cy   <= '0;
        end else begin
            if (w_take) begin
                r_sum_x <= w_sum_x_n;
                r_sum_y <= w_sum_y_n;
            end
            if (w_eof_take) begin
                r_res_cx   <= '0;
                r_res_cy   <= '0;
                r_div_step <= '0;
                r_div_q    <= '0;
                r_div_rem  <= w_sum_x_n[X_W+CNT_W-1 -: CNT_W];
                r_div_lo   <= c_QW'(w_sum_x_n[X_W-1:0]) << (c_QW - X_W);
            end else if (r_state == S_DIV) begin
                r_div_step <= r_div_step + 1'b1;
                if (r_div_step == c_STEP_X_END) begin
                    r_res_cx  <= w_div_q_n[X_W-1:0];
                    r_div_q   <= '0;
                    r_div_rem <= r_sum_y[Y_W+CNT_W-1 -: CNT_W];
                    r_div_lo  <= c_QW'(r_sum_y[Y_W-1:0]) << (c_QW - Y_W);
                end else begin
                    if (r_div_step == c_STEP_END) r_res_cy <= w_div_q_n[Y_W-1:0];
                    r_div_q   <= w_div_q_n;
                    r_div_rem <= w_div_rem_n;
                    r_div_lo  <= r_div_lo << 1;
                end
            end
        end
    end

    assign res_cx = r_res_cx;
    assign res_cy = r_res_cy;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_eof_take) begin
`ifdef YELLOW_CENTROID_EN
                    w_state_n = w_found_n ? S_DIV : S_REPORT;
`else
                    w_state_n = S_REPORT;
`endif
                end else if (w_take) begin
                    w_state_n = S_ACCUM;
                end
            end
`ifdef YELLOW_CENTROID_EN
            S_DIV:    if (r_div_step == c_STEP_END) w_state_n = S_REPORT;
`endif
            S_REPORT: if (res_ready) w_state_n = S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef YELLOW_CENTROID_EN
        w_busy = (r_state == S_REPORT) || (r_state == S_DIV);
`else
        w_busy = (r_state == S_REPORT);
`endif
        res_valid  = (r_state == S_REPORT);
        frame_drop = w_busy && mask_valid && mask_sof;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_count     <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_res_found <= 1'b0;
            r_res_count <= '0;
            r_res_xmin  <= '0;
            r_res_xmax  <= '0;
            r_res_ymin  <= '0;
            r_res_ymax  <= '0;
        end else if (w_take) begin
            r_x     <= w_nxt_x;
            r_y     <= w_nxt_y;
            r_count <= w_count_n;
            r_xmin  <= w_xmin_n;
            r_xmax  <= w_xmax_n;
            r_ymin  <= w_ymin_n;
            r_ymax  <= w_ymax_n;
            if (mask_eof) begin
                r_res_found <= w_found_n;
                r_res_count <= w_count_n;
                r_res_xmin  <= w_found_n ? w_xmin_n : '0;
                r_res_xmax  <= w_found_n ? w_xmax_n : '0;
                r_res_ymin  <= w_found_n ? w_ymin_n : '0;
                r_res_ymax  <= w_found_n ? w_ymax_n : '0;
            end
        end
    end

    assign res_found = r_res_found;
    assign res_count = r_res_count;
    assign res_xmin  = r_res_xmin;
    assign res_xmax  = r_res_xmax;
    assign res_ymin  = r_res_ymin;
    assign res_ymax  = r_res_ymax;

endmodule

`default_nettype wire

// File: tb/tb_yellow_blob_tracker.sv
// ============================================================================
//  Module   : tb_yellow_blob_tracker
//  Purpose  : Directed and randomized frames against a row/column reference
//             model of yellow_blob_tracker (honours YELLOW_CENTROID_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yellow_blob_tracker;

    localparam int H_MAX   = 8;
    localparam int V_MAX   = 4;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int CNT_W   = 19;
    localparam int MIN_PIX = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mask_valid, mask_bit, mask_sof, mask_eol, mask_eof;
    logic             res_valid, res_ready, res_found, frame_drop;
    logic [CNT_W-1:0] res_count;
    logic [X_W-1:0]   res_xmin, res_xmax;
    logic [Y_W-1:0]   res_ymin, res_ymax;
`ifdef YELLOW_CENTROID_EN
    logic [X_W-1:0]   res_cx;
    logic [Y_W-1:0]   res_cy;
    localparam int c_DIV_LAT = X_W + Y_W;
`else
    localparam int c_DIV_LAT = 0;
`endif

    yellow_blob_tracker #(
        .H_MAX(H_MAX), .V_MAX(V_MAX), .X_W(X_W), .Y_W(Y_W),
        .CNT_W(CNT_W), .MIN_PIX(MIN_PIX)
    ) dut (
        .clk(clk), .rst(rst),
        .mask_valid(mask_valid), .mask_bit(mask_bit), .mask_sof(mask_sof),
        .mask_eol(mask_eol), .mask_eof(mask_eof),
        .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
        .res_count(res_count),
        .res_xmin(res_xmin), .res_xmax(res_xmax),
        .res_ymin(res_ymin), .res_ymax(res_ymax),
`ifdef YELLOW_CENTROID_EN
        .res_cx(res_cx), .res_cy(res_cy),
`endif
        .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit bmp [0:15][0:15];
    int e_cnt, e_found, e_xmin, e_xmax, e_ymin, e_ymax, e_cx, e_cy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-cycle inputs carry random junk that must be ignored.
    task automatic px(input logic b, input logic s, input logic l, input logic e);
        mask_valid = 1'b1; mask_bit = b; mask_sof = s; mask_eol = l; mask_eof = e;
        tick();
        mask_valid = 1'b0;
        {mask_bit, mask_sof, mask_eol, mask_eof} = 4'($urandom);
    endtask

    task automatic clear_bmp();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                bmp[r][c] = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (gaps && ($urandom_range(0, 3) == 0)) tick();
                px(bmp[r][c], (r == 0) && (c == 0), c == w - 1, (r == h - 1) && (c == w - 1));
            end
    endtask

    // Reference: pixel (row, col) lands at (min(col,H_MAX-1), min(row,V_MAX-1)).
    task automatic model(input int w, input int h);
        int sx, sy, x, y;
        e_cnt = 0; sx = 0; sy = 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (bmp[r][c]) begin
                    x = (c < H_MAX) ? c : H_MAX - 1;
                    y = (r < V_MAX) ? r : V_MAX - 1;
                    if (e_cnt == 0) begin
                        e_xmin = x; e_xmax = x; e_ymin = y; e_ymax = y;
                    end else begin
                        if (x < e_xmin) e_xmin = x;
                        if (x > e_xmax) e_xmax = x;
                        if (y < e_ymin) e_ymin = y;
                        if (y > e_ymax) e_ymax = y;
                    end
                    e_cnt++; sx += x; sy += y;
                end
        e_found = (e_cnt >= MIN_PIX) ? 1 : 0;
        if (e_found == 0) begin
            e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cx = 0; e_cy = 0;
        end else begin
            e_cx = sx / e_cnt; e_cy = sy / e_cnt;
        end
    endtask

    // Entered one cycle after the eof pixel was sampled.
    task automatic check_result(input string tag);
        int lat;
        lat = (e_found != 0) ? c_DIV_LAT : 0;
        if (lat > 0) begin
            chk({tag, "_early"}, res_valid, 0);
            repeat (lat) tick();
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_found"}, res_found, e_found);
        chk({tag, "_count"}, res_count, e_cnt);
        chk({tag, "_xmin"},  res_xmin,  e_xmin);
        chk({tag, "_xmax"},  res_xmax,  e_xmax);
        chk({tag, "_ymin"},  res_ymin,  e_ymin);
        chk({tag, "_ymax"},  res_ymax,  e_ymax);
`ifdef YELLOW_CENTROID_EN
        chk({tag, "_cx"}, res_cx, e_cx);
        chk({tag, "_cy"}, res_cy, e_cy);
`endif
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_released"}, res_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        mask_valid = 1'b0; mask_bit = 1'b0; mask_sof = 1'b0; mask_eol = 1'b0; mask_eof = 1'b0;
        repeat (3) tick();
        chk("reset_valid", res_valid, 0);
        chk("reset_count", res_count, 0);
        chk("reset_found", res_found, 0);
        chk("reset_drop",  frame_drop, 0);
        rst = 1'b0;
        tick();

        // Three yellow pixels in an 8x4 frame.
        clear_bmp();
        bmp[1][2] = 1'b1; bmp[1][5] = 1'b1; bmp[2][3] = 1'b1;
        model(8, 4);
        send_frame(8, 4, 1'b0);
        check_result("plan3");

        // Backpressure with a sof arriving while the result is held.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                mask_valid = 1'b1; mask_bit = 1'b1; mask_sof = 1'b1; mask_eol = 1'b0; mask_eof = 1'b0;
                #1;
                chk("bp_drop", frame_drop, 1);
                tick();
                mask_valid = 1'b0; mask_sof = 1'b0;
            end else begin
                tick();
            end
            if (i == 5) chk("bp_nodrop", frame_drop, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_count", res_count, 3);
            chk("bp_xmax",  res_xmax, 5);
        end
        accept("bp");
        px(1'b1, 1'b0, 1'b0, 1'b0);
        px(1'b1, 1'b0, 1'b1, 1'b0);
        px(1'b1, 1'b0, 1'b1, 1'b1);
        chk("skipped_frame", res_valid, 0);
        tick();
        chk("skipped_frame2", res_valid, 0);

        // Single yellow pixel: below threshold.
        clear_bmp();
        bmp[1][3] = 1'b1;
        model(8, 4);
        send_frame(8, 4, 1'b0);
        check_result("single");
        accept("single");

        // Partial frame with 3 yellows, then a fresh sof with 2 yellows.
        px(1'b1, 1'b1, 1'b0, 1'b0);
        px(1'b1, 1'b0, 1'b0, 1'b0);
        px(1'b1, 1'b0, 1'b0, 1'b0);
        clear_bmp();
        bmp[0][1] = 1'b1; bmp[1][0] = 1'b1;
        model(4, 2);
        send_frame(4, 2, 1'b0);
        check_result("resof");
        accept("resof");

        // Every pixel yellow, full frame.
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                bmp[r][c] = 1'b1;
        model(8, 4);
        send_frame(8, 4, 1'b0);
        check_result("full");
        accept("full");

        // Over-long line and over-tall frame saturate both coordinates.
        model(12, 6);
        send_frame(12, 6, 1'b0);
        check_result("sat");
        chk("sat_xmax_edge", res_xmax, H_MAX - 1);
        chk("sat_ymax_edge", res_ymax, V_MAX - 1);
        accept("sat");

        // Reset mid-frame, then an orphan eof.
        px(1'b1, 1'b1, 1'b0, 1'b0);
        px(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_accum_valid", res_valid, 0);
        #1;
        rst = 1'b0;
        tick();
        px(1'b1, 1'b0, 1'b0, 1'b1);
        chk("orphan_eof_a", res_valid, 0);

        // Reset while holding a result.
        clear_bmp();
        bmp[0][0] = 1'b1; bmp[2][6] = 1'b1;
        model(8, 4);
        send_frame(8, 4, 1'b0);
        check_result("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_report_valid", res_valid, 0);
        chk("rst_report_count", res_count, 0);
        #1;
        rst = 1'b0;
        tick();
        px(1'b1, 1'b0, 1'b1, 1'b1);
        chk("orphan_eof_b", res_valid, 0);
        tick();
        chk("orphan_eof_c", res_valid, 0);

        // Randomized frames with idle gaps.
        for (int f = 0; f < 20; f++) begin
            int w, h, dens;
            w = $urandom_range(1, 11);
            h = $urandom_range(1, 6);
            dens = $urandom_range(0, 4);
            clear_bmp();
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    bmp[r][c] = ($urandom_range(0, 3) < dens);
            model(w, h);
            send_frame(w, h, 1'b1);
            check_result("rnd");
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_hold", res_valid, 1);
            accept("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/yellow_blob_tracker.md
Name: yellow_blob_tracker

Overview:
- Consumes the per-pixel yellow mask stream produced by the colour-threshold stage, one mask bit per accepted pixel in raster order.
- Tracks pixel coordinates from frame/line markers and accumulates the yellow pixel count and bounding box over one frame.
- At end of frame, presents the result on a valid/ready handshake to the downstream controller (steering/overlay logic).

Parameters:
- H_MAX, 640, maximum pixels per line; the x coordinate saturates at H_MAX-1.
- V_MAX, 480, maximum lines per frame; the y coordinate saturates at V_MAX-1.
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- CNT_W, 19, yellow pixel count width.
- MIN_PIX, 16, minimum yellow count for a detection.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mask_valid  in  1  pixel strobe; all other mask_* inputs are sampled only when this is 1.
- mask_bit  in  1  1 = pixel classified yellow.
- mask_sof  in  1  this pixel is (0,0) of a new frame.
- mask_eol  in  1  this pixel is the last pixel of its line.
- mask_eof  in  1  this pixel is the last pixel of the frame.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_found  out  1  1 when count >= MIN_PIX.
- res_count  out  CNT_W  yellow pixel count, saturating.
- res_xmin, res_xmax  out  X_W  bounding box x limits.
- res_ymin, res_ymax  out  Y_W  bounding box y limits.
- frame_drop  out  1  one-cycle pulse when a sof is discarded.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; internal counters and accumulators cleared. Reset mid-frame or mid-report abandons the frame with no result.
- States:
  - IDLE: wait for a valid pixel with mask_sof.
  - ACCUM: process pixels.
  - (DIV, only with the optional feature.)
  - REPORT: hold results.
- Coordinates:
  - A pixel with sof is (0,0).
  - After each valid pixel, x increments, saturating at H_MAX-1.
  - A pixel with eol sets x to 0 and increments y for the next pixel; y saturates at V_MAX-1.
- Accumulation on a valid pixel with mask_bit=1:
  - count increments, saturating at all-ones.
  - xmin/xmax/ymin/ymax update with min/max.
  - The first yellow pixel of a frame initialises all four limits to its coordinates.
- sof received in ACCUM: the partial frame is discarded and accumulation restarts at that pixel (no frame_drop).
- sof in IDLE: accumulation starts with that pixel. Pixels without sof in IDLE are ignored.
- A pixel with both sof and eof is a complete one-pixel frame.
- eof pixel:
  - The pixel is accumulated first.
  - Next cycle, with the feature off, res_* are registered and res_valid=1 (REPORT).
  - Latency from the eof pixel to res_valid is 1 cycle.
- Results:
  - res_found = (count >= MIN_PIX).
  - When res_found=0, the bbox outputs are 0 and res_count still reports the true count.
- REPORT:
  - res_valid and res_* stay stable until the cycle where res_valid & res_ready = 1.
  - The next cycle, res_valid=0 and state is IDLE.
  - Pixels arriving in REPORT are ignored. A sof arriving in REPORT produces frame_drop=1 for that cycle and the frame is skipped.
- eof arriving while in IDLE is ignored.

Optional Feature:
- Macro: YELLOW_CENTROID_EN
- Enabled:
  - Adds sum_x (X_W+CNT_W bits) and sum_y (Y_W+CNT_W bits) accumulators.
  - Adds ports res_cx (out, X_W) and res_cy (out, Y_W), where cx = floor(sum_x/count) and cy = floor(sum_y/count).
  - Both quotients come from one shared serial restoring divider, one quotient bit per cycle: X_W cycles for cx, then Y_W cycles for cy (state DIV).
  - When res_found=1, res_valid asserts at eof+1+X_W+Y_W cycles.
  - When res_found=0, the divider is skipped, cx=cy=0, and latency is 1.
  - Pixels and sof during DIV are treated as in REPORT.
- Disabled: no sum registers, divider, DIV state or centroid ports.

Test Plan:
- H_MAX=8, V_MAX=4, MIN_PIX=2, 4x8 frame with yellow at (2,1), (5,1), (3,2) -> one cycle after eof: res_valid=1, found=1, count=3, xmin=2, xmax=5, ymin=1, ymax=2. With the feature: cx=3, cy=1, valid at eof+1+X_W+Y_W.
- Frame with a single yellow pixel, MIN_PIX=2 -> found=0, count=1, bbox all 0.
- res_ready held 0 for 10 cycles, a new frame's sof arrives during that time -> res_* stable, frame_drop pulse on that sof cycle, that frame produces no result. res_ready=1 -> res_valid drops the next cycle.
- sof reasserted mid-frame after 3 yellow pixels, then the new frame has 2 yellow pixels -> count=2.
- Every pixel yellow on a full 640x480 frame -> count=307200, bbox (0,0)-(639,479). A line of 700 pixels without eol -> x saturates at 639.
- rst asserted mid-ACCUM and during REPORT -> res_valid=0 immediately (asynchronous). The next eof without a preceding sof yields no result.
